// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and widths for the fetch/data memory-port arbiter.
package riscv_mem_pkg;

  localparam int unsigned XLEN = 64;
  localparam int unsigned ILEN = 32;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    RESP,
    FAULT
  } state_e;

  typedef enum logic {
    OWN_IF,
    OWN_DM
  } owner_e;

  // Fetches need 4-byte alignment, data accesses need full 8-byte alignment.
  function automatic logic misaligned(input logic [2:0] lsb, input owner_e who);
    return (who == OWN_DM) ? (lsb != 3'b000) : (lsb[1:0] != 2'b00);
  endfunction

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Requester and memory-port signals of the arbiter; master is the arbiter's view.
interface mem_port_arbiter_if;
  import riscv_mem_pkg::*;

  logic            if_req;
  logic [XLEN-1:0] if_addr;
  logic            if_done;
  logic [ILEN-1:0] if_rdata;
  logic            if_err;

  logic            dm_req;
  logic            dm_we;
  logic [XLEN-1:0] dm_addr;
  logic [XLEN-1:0] dm_wdata;
  logic            dm_done;
  logic [XLEN-1:0] dm_rdata;
  logic            dm_err;

  logic            if_stall;
  logic            dm_stall;

  logic            mem_req;
  logic            mem_we;
  logic [XLEN-1:0] mem_addr;
  logic [XLEN-1:0] mem_wdata;
  logic            mem_gnt;
  logic            mem_rvalid;
  logic [XLEN-1:0] mem_rdata;

  logic            fault;

  modport master (
    input  if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata,
    input  mem_gnt, mem_rvalid, mem_rdata,
    output if_done, if_rdata, if_err, dm_done, dm_rdata, dm_err,
    output if_stall, dm_stall,
    output mem_req, mem_we, mem_addr, mem_wdata, fault
  );

  modport slave (
    output if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata,
    output mem_gnt, mem_rvalid, mem_rdata,
    input  if_done, if_rdata, if_err, dm_done, dm_rdata, dm_err,
    input  if_stall, dm_stall,
    input  mem_req, mem_we, mem_addr, mem_wdata, fault
  );

endinterface

// File: rtl/mem_port_arbiter_timeout_counter.sv
// Watchdog counter: cleared at grant, counts while a memory access is outstanding.
module mem_timeout_counter #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic clock,
  input  logic reset,
  input  logic clear_i,
  input  logic enable_i,
  output logic expired_o
);

  localparam logic [15:0] LIMIT = 16'(TIMEOUT);

  logic [15:0] count_q;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      count_q <= '0;
    end else if (clear_i) begin
      count_q <= '0;
    end else if (enable_i && !expired_o) begin
      count_q <= count_q + 16'd1;
    end
  end

  assign expired_o = (count_q == LIMIT);

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one 64-bit memory port between instruction fetch and load/store,
// one transaction at a time, with a watchdog that latches a sticky fault.
module mem_port_arbiter
  import riscv_mem_pkg::*;
#(
  parameter int unsigned TIMEOUT = 255
) (
  input logic               clock,
  input logic               reset,
  mem_port_arbiter_if.master bus
);

  state_e          state_q;
  owner_e          owner_q;
  owner_e          last_owner_q;
  logic            hi_word_q;

  logic            if_done_q;
  logic            if_err_q;
  logic [ILEN-1:0] if_rdata_q;
  logic            dm_done_q;
  logic            dm_err_q;
  logic [XLEN-1:0] dm_rdata_q;

  logic            mem_req_q;
  logic            mem_we_q;
  logic [XLEN-1:0] mem_addr_q;
  logic [XLEN-1:0] mem_wdata_q;
  logic            fault_q;

  logic            if_elig;
  logic            dm_elig;
  logic            grant_if_d;
  logic            grant_dm_d;
  logic            wd_fire_d;
  logic            expired;

  // A requester still holding req during its own done cycle is not re-granted.
  always_comb begin
    if_elig    = bus.if_req & ~if_done_q;
    dm_elig    = bus.dm_req & ~dm_done_q;
    grant_dm_d = 1'b0;
    grant_if_d = 1'b0;
    if (state_q == IDLE) begin
      grant_dm_d = dm_elig && (!if_elig || last_owner_q == OWN_IF);
      grant_if_d = if_elig && !grant_dm_d;
    end
    // A response arriving on the expiry cycle wins over the watchdog.
    wd_fire_d = expired &&
                ((state_q == REQ) || (state_q == RESP && !bus.mem_rvalid));
  end

  mem_timeout_counter #(
    .TIMEOUT (TIMEOUT)
  ) u_watchdog (
    .clock     (clock),
    .reset     (reset),
    .clear_i   (grant_if_d | grant_dm_d),
    .enable_i  ((state_q == REQ) || (state_q == RESP)),
    .expired_o (expired)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      owner_q      <= OWN_IF;
      last_owner_q <= OWN_IF;
      hi_word_q    <= 1'b0;
      if_done_q    <= 1'b0;
      if_err_q     <= 1'b0;
      if_rdata_q   <= '0;
      dm_done_q    <= 1'b0;
      dm_err_q     <= 1'b0;
      dm_rdata_q   <= '0;
      mem_req_q    <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      fault_q      <= 1'b0;
    end else begin
      if_done_q <= 1'b0;
      dm_done_q <= 1'b0;

      if (wd_fire_d) begin
        mem_req_q <= 1'b0;
        fault_q   <= 1'b1;
        state_q   <= FAULT;
        if (owner_q == OWN_IF) begin
          if_done_q  <= 1'b1;
          if_err_q   <= 1'b1;
          if_rdata_q <= '0;
        end else begin
          dm_done_q  <= 1'b1;
          dm_err_q   <= 1'b1;
          dm_rdata_q <= '0;
        end
      end else begin
        case (state_q)
          IDLE: begin
            if (grant_dm_d) begin
              last_owner_q <= OWN_DM;
              if (misaligned(bus.dm_addr[2:0], OWN_DM)) begin
                dm_done_q  <= 1'b1;
                dm_err_q   <= 1'b1;
                dm_rdata_q <= '0;
              end else begin
                owner_q     <= OWN_DM;
                mem_req_q   <= 1'b1;
                mem_we_q    <= bus.dm_we;
                mem_addr_q  <= {bus.dm_addr[XLEN-1:3], 3'b000};
                mem_wdata_q <= bus.dm_wdata;
                state_q     <= REQ;
              end
            end else if (grant_if_d) begin
              last_owner_q <= OWN_IF;
              if (misaligned(bus.if_addr[2:0], OWN_IF)) begin
                if_done_q  <= 1'b1;
                if_err_q   <= 1'b1;
                if_rdata_q <= '0;
              end else begin
                owner_q     <= OWN_IF;
                hi_word_q   <= bus.if_addr[2];
                mem_req_q   <= 1'b1;
                mem_we_q    <= 1'b0;
                mem_addr_q  <= {bus.if_addr[XLEN-1:3], 3'b000};
                mem_wdata_q <= '0;
                state_q     <= REQ;
              end
            end
          end

          REQ: begin
            if (bus.mem_gnt) begin
              mem_req_q <= 1'b0;
              state_q   <= RESP;
            end
          end

          RESP: begin
            if (bus.mem_rvalid) begin
              state_q <= IDLE;
              if (owner_q == OWN_IF) begin
                if_done_q  <= 1'b1;
                if_err_q   <= 1'b0;
                if_rdata_q <= hi_word_q ? bus.mem_rdata[XLEN-1:ILEN]
                                        : bus.mem_rdata[ILEN-1:0];
              end else begin
                dm_done_q  <= 1'b1;
                dm_err_q   <= 1'b0;
                dm_rdata_q <= mem_we_q ? '0 : bus.mem_rdata;
              end
            end
          end

          FAULT: begin
            if (if_elig) begin
              if_done_q  <= 1'b1;
              if_err_q   <= 1'b1;
              if_rdata_q <= '0;
            end
            if (dm_elig) begin
              dm_done_q  <= 1'b1;
              dm_err_q   <= 1'b1;
              dm_rdata_q <= '0;
            end
          end
        endcase
      end
    end
  end

  assign bus.if_done   = if_done_q;
  assign bus.if_err    = if_err_q;
  assign bus.if_rdata  = if_rdata_q;
  assign bus.dm_done   = dm_done_q;
  assign bus.dm_err    = dm_err_q;
  assign bus.dm_rdata  = dm_rdata_q;
  assign bus.if_stall  = bus.if_req & ~if_done_q;
  assign bus.dm_stall  = bus.dm_req & ~dm_done_q;
  assign bus.mem_req   = mem_req_q;
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;
  assign bus.fault     = fault_q;

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Shares one single-ported 64-bit memory between the instruction-fetch stage and the MEM (load/store) stage of the 5-stage RISC-V pipeline. It accepts one request at a time and sequences it onto the memory port through a grant/response handshake. It returns fetch and data results with per-requester stall signals, which feed PCWrite/IF_ID_Write and the pipeline-register hold logic. A watchdog detects a hung memory and latches a fault.

## Interface
Parameters:
- TIMEOUT, 255: maximum cycles from grant to memory response before fault; range 1..65535.

Ports (clock and reset: one clock; reset is asynchronous and active-high):
- clock  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high reset
- if_req  in  1  fetch request; held until if_done
- if_addr  in  64  fetch byte address (PC)
- if_done  out  1  one-cycle pulse; if_rdata/if_err valid
- if_rdata  out  32  instruction
- if_err  out  1  misaligned fetch or fault
- dm_req  in  1  data request; held until dm_done
- dm_we  in  1  1 = store, 0 = load
- dm_addr  in  64  data byte address (ALU result)
- dm_wdata  in  64  store data
- dm_done  out  1  one-cycle pulse
- dm_rdata  out  64  load data
- dm_err  out  1  misaligned access or fault
- if_stall  out  1  if_req & ~if_done (combinational)
- dm_stall  out  1  dm_req & ~dm_done (combinational)
- mem_req  out  1  memory request; held until mem_gnt
- mem_we  out  1  write enable
- mem_addr  out  64  word-aligned byte address
- mem_wdata  out  64  write data
- mem_gnt  in  1  memory accepted request
- mem_rvalid  in  1  response (read data or write acknowledge)
- mem_rdata  in  64  read data
- fault  out  1  sticky timeout indicator

## Operation
- States:
  - IDLE → REQ on a grant.
  - REQ → RESP on mem_gnt.
  - RESP → IDLE on mem_rvalid.
  - REQ or RESP → FAULT when the timer reaches TIMEOUT.
  - FAULT is held until reset.
- Grant in IDLE:
  - A requester is eligible when its req is high and its done is not high in the current cycle. This prevents re-issue of a request still held during its done cycle.
  - If both are eligible, data wins, unless the last grant was data; then fetch wins.
  - The last-owner bit resets to fetch.
- Alignment is checked at grant:
  - Fetch with if_addr[1:0] ≠ 0 completes with if_err=1 and no memory access.
  - Data with dm_addr[2:0] ≠ 0 completes with dm_err=1 and no memory access.
  - The error done pulse is asserted the cycle after the grant; the state stays IDLE.
- Address, we, wdata and owner are latched at grant; requester inputs are ignored afterwards. mem_addr = {addr[63:3], 3'b000}. Fetch is always a read.
- Fetch data: if_rdata = addr[2] ? mem_rdata[63:32] : mem_rdata[31:0], registered.
- Loads return mem_rdata in dm_rdata. Stores return dm_rdata = 0.
- Watchdog:
  - Cleared at grant; increments each cycle in REQ/RESP.
  - Reaching TIMEOUT drives the owner's done with err=1, deasserts mem_req and enters FAULT.
- In FAULT, every eligible request completes the next cycle with err=1, and mem_req stays 0.
- mem_rvalid outside RESP and mem_gnt outside REQ are ignored.

## Timing
- Reset values: all outputs 0; state IDLE; timer 0.
- Reset mid-transaction aborts immediately: mem_req drops asynchronously and no done is issued. The memory shares the same reset.
- Minimum latency:
  - Request sampled at edge k.
  - mem_req high from k+1.
  - mem_gnt in the same cycle, mem_rvalid in the next.
  - done plus data at k+3.
- done, rdata and err are registered. rdata holds until the next done for that requester.
- The watchdog timeout and mem_rvalid in the same cycle count as the response; no fault.
- Back-to-back grants: the earliest is the cycle after done, i.e. one idle cycle between transactions.

## Structure
- Package riscv_mem_pkg:
  - state enum {IDLE, REQ, RESP, FAULT}
  - owner enum {OWN_IF, OWN_DM}
  - width constants XLEN=64, ILEN=32
- Sub-module mem_timeout_counter holds the watchdog counter, with clear/enable/expired signals and a TIMEOUT parameter.

## Test plan
- Single fetch: if_addr=0x104, memory returns 0xAABBCCDD_11223344 with 0 wait states → if_done at request+3, if_rdata=0xAABBCCDD, mem_addr=0x100.
- Simultaneous dm_req (load from 0x8) and if_req after a fetch grant → data granted first, fetch second, dm_rdata=0x1F. Then hold both requests continuously → grants alternate.
- Store 0x55 to 0x10 with mem_gnt delayed 3 cycles → mem_req held 4 cycles, mem_we=1, dm_done after mem_rvalid, dm_err=0.
- Misaligned dm_addr=0x0C → dm_done+dm_err one cycle later, mem_req never asserted. Also fetch at 0x102 → if_err.
- TIMEOUT=4, memory never grants → owner's done with err at grant+5 cycles, fault=1. Subsequent if_req → error done with no memory access.
- Assert reset while in RESP → mem_req=0 and all outputs 0 immediately. A stale mem_rvalid after reset produces no done.
